// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive safety checker for the two-road light bus. It registers both 3-bit
// one-hot light codes, tracks each road's phase and raises sticky error flags:
//   [0] onehot, [1] conflict, [2] seq, [3] time.
// It also counts completed road-2 signal cycles.
// Optional macro TRAFFIC_MON_TIMING_EN adds the tick prescaler, the per-road
// phase-duration counters and the time check. Without it, err_vec[3] stays 0.
module traffic_light_monitor #(
  parameter int TICK_DIV = 4,
  parameter int CW       = 8,
  parameter int YEL_MIN  = 2,
  parameter int YEL_MAX  = 3,
  parameter int GRN_MIN  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [2:0] road1_in,
  input  logic [2:0] road2_in,
  output logic [3:0] err_vec,
  output logic       alarm,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [2:0] {
    PH_UNK    = 3'd0,
    PH_RED    = 3'd1,
    PH_YEL_UP = 3'd2,
    PH_GRN    = 3'd3,
    PH_YEL_DN = 3'd4
  } phase_t;

  localparam logic [2:0] CODE_RED = 3'b001;
  localparam logic [2:0] CODE_YEL = 3'b010;
  localparam logic [2:0] CODE_GRN = 3'b100;

  logic [2:0] s1, s2;
  phase_t     ph1_reg, ph1_next, ph2_reg, ph2_next;
  logic       valid1, valid2;
  logic       onehot_hit, conflict_hit, seq_hit, time_hit, cycle_hit;
  logic [3:0] err_next;

  function automatic logic is_valid(input logic [2:0] code);
    return (code == CODE_RED) || (code == CODE_YEL) || (code == CODE_GRN);
  endfunction

  // Next phase for one road. Invalid codes hold the phase. UNK waits for RED.
  // Yellow is ambiguous, so the current phase decides whether it is the
  // rising (after red) or falling (after green) yellow.
  function automatic phase_t phase_step(input phase_t ph, input logic [2:0] code);
    phase_t nxt;
    nxt = ph;
    if (ph == PH_UNK) begin
      if (code == CODE_RED) nxt = PH_RED;
    end else begin
      case (code)
        CODE_RED: nxt = PH_RED;
        CODE_GRN: nxt = PH_GRN;
        CODE_YEL: begin
          if (ph == PH_RED)      nxt = PH_YEL_UP;
          else if (ph == PH_GRN) nxt = PH_YEL_DN;
        end
        default: nxt = ph;
      endcase
    end
    return nxt;
  endfunction

  // A phase change that skips its legal successor.
  function automatic logic seq_bad(input phase_t ph, input phase_t nxt);
    return ((ph == PH_RED)    && (nxt == PH_GRN)) ||
           ((ph == PH_YEL_UP) && (nxt == PH_RED)) ||
           ((ph == PH_GRN)    && (nxt == PH_RED)) ||
           ((ph == PH_YEL_DN) && (nxt == PH_GRN));
  endfunction

  // Input stage: capture the light bus. Both roads reset to RED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= CODE_RED;
      s2 <= CODE_RED;
    end else begin
      s1 <= road1_in;
      s2 <= road2_in;
    end
  end

  // Phase decode for both roads from the registered samples.
  always_comb begin
    valid1   = is_valid(s1);
    valid2   = is_valid(s2);
    ph1_next = phase_step(ph1_reg, s1);
    ph2_next = phase_step(ph2_reg, s2);
  end

  // Per-road phase state registers. Both roads re-synchronise through UNK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1_reg <= PH_UNK;
      ph2_reg <= PH_UNK;
    end else begin
      ph1_reg <= ph1_next;
      ph2_reg <= ph2_next;
    end
  end

`ifdef TRAFFIC_MON_TIMING_EN
  localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  YEL_LO   = CW'(YEL_MIN);
  localparam logic [CW-1:0]  YEL_HI   = CW'(YEL_MAX);
  localparam logic [CW-1:0]  GRN_LO   = CW'(GRN_MIN);

  logic [PW-1:0] pre_reg;
  logic          tick;
  logic          chg1, chg2;
  logic [CW-1:0] dur1_reg, dur1_next, dur2_reg, dur2_next;

  // Duration rule for leaving a phase. UNK and RED have no limit.
  function automatic logic time_bad(input phase_t ph, input logic [CW-1:0] dur);
    case (ph)
      PH_YEL_UP, PH_YEL_DN: return (dur < YEL_LO) || (dur > YEL_HI);
      PH_GRN:               return dur < GRN_LO;
      default:              return 1'b0;
    endcase
  endfunction

  // A phase change clears the counter and swallows a coincident tick.
  // Invalid samples freeze the counter. The counter saturates at all-ones.
  function automatic logic [CW-1:0] dur_step(input logic [CW-1:0] dur, input logic chg,
                                             input logic valid, input logic tk);
    if (chg)                            return '0;
    else if (valid && tk && dur != '1)  return dur + 1'b1;
    else                                return dur;
  endfunction

  assign tick = (pre_reg == PRE_LAST);

  // Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_reg <= '0;
    else if (tick) pre_reg <= '0;
    else           pre_reg <= pre_reg + 1'b1;
  end

  // Phase-change detection, counter update and exit-duration check.
  always_comb begin
    chg1      = (ph1_next != ph1_reg);
    chg2      = (ph2_next != ph2_reg);
    dur1_next = dur_step(dur1_reg, chg1, valid1, tick);
    dur2_next = dur_step(dur2_reg, chg2, valid2, tick);
    time_hit  = (chg1 && time_bad(ph1_reg, dur1_reg)) ||
                (chg2 && time_bad(ph2_reg, dur2_reg));
  end

  // Per-road phase-duration counters in ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur1_reg <= '0;
      dur2_reg <= '0;
    end else begin
      dur1_reg <= dur1_next;
      dur2_reg <= dur2_next;
    end
  end
`else
  assign time_hit = 1'b0;
`endif

  // Error sources for this sample, plus the sticky-flag update. clr loses to a
  // new error in the same cycle.
  always_comb begin
    onehot_hit   = !valid1 || !valid2;
    conflict_hit = valid1 && valid2 && (s1 != CODE_RED) && (s2 != CODE_RED);
    seq_hit      = seq_bad(ph1_reg, ph1_next) || seq_bad(ph2_reg, ph2_next);
    cycle_hit    = (ph2_reg == PH_YEL_DN) && (ph2_next == PH_RED);
    err_next     = (clr ? 4'b0000 : err_vec) |
                   {time_hit, seq_hit, conflict_hit, onehot_hit};
  end

  // Sticky error flags and the completed-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vec   <= 4'b0000;
      cycle_cnt <= 8'd0;
    end else begin
      err_vec <= err_next;
      if (cycle_hit) cycle_cnt <= cycle_cnt + 8'd1;
    end
  end

  assign alarm = |err_vec;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor.
// Stimulus is a sequence of directed and randomised steps. A phase-position
// reference model predicts err_vec, alarm and cycle_cnt after every clock.
// The time-check expectations follow TRAFFIC_MON_TIMING_EN.
module tb_traffic_light_monitor;
  localparam int TD = 4;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;
`ifdef TRAFFIC_MON_TIMING_EN
  localparam logic [3:0] TIME_FLAG = 4'b1000;
`else
  localparam logic [3:0] TIME_FLAG = 4'b0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] road1 = R;
  logic [2:0] road2 = R;
  logic [3:0] err_vec;
  logic       alarm;
  logic [7:0] cycle_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  // Position in the legal cycle: 0 red, 1 yellow-up, 2 green, 3 yellow-down.
  // -1 means the phase is unknown.
  int         n_edges;
  logic [2:0] m_s [2];
  int         m_pos [2];
  int         m_start [2];
  int         m_lost [2];
  logic [3:0] m_err;
  logic [7:0] m_cyc;
  int         colors [4] = '{1, 2, 4, 2};

  traffic_light_monitor #(
    .TICK_DIV(TD), .CW(8), .YEL_MIN(2), .YEL_MAX(3), .GRN_MIN(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .road1_in(road1), .road2_in(road2),
    .err_vec(err_vec), .alarm(alarm), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n_edges = 0;
    m_err   = 4'b0000;
    m_cyc   = 8'd0;
    for (int r = 0; r < 2; r++) begin
      m_s[r]     = R;
      m_pos[r]   = -1;
      m_start[r] = 0;
      m_lost[r]  = 0;
    end
  endtask

  // One clock edge of the model. Samples captured at the previous edge are
  // judged now; the pins seen at this edge become the next samples.
  task automatic model_edge();
    logic [3:0] hit;
    bit         v [2];
    int         tgt;
`ifdef TRAFFIC_MON_TIMING_EN
    int         cnt;
`endif
    hit = 4'b0000;
    n_edges++;
    for (int r = 0; r < 2; r++)
      v[r] = (m_s[r] == R) || (m_s[r] == Y) || (m_s[r] == G);
    if (!v[0] || !v[1]) hit[0] = 1'b1;
    if (v[0] && v[1] && m_s[0] != R && m_s[1] != R) hit[1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (!v[r]) begin
        if (n_edges % TD == 0) m_lost[r]++;
      end else if (m_pos[r] < 0) begin
        if (m_s[r] == R) begin
          m_pos[r] = 0; m_start[r] = n_edges; m_lost[r] = 0;
        end
      end else if (int'(m_s[r]) != colors[m_pos[r]]) begin
        tgt = (m_s[r] == R) ? 0 : (m_s[r] == G) ? 2 : m_pos[r] + 1;
        if (tgt != (m_pos[r] + 1) % 4) hit[2] = 1'b1;
`ifdef TRAFFIC_MON_TIMING_EN
        // Ticks land on edges that are multiples of TD, strictly between the
        // entry edge and this one, minus those that hit an invalid sample.
        cnt = (n_edges - 1) / TD - m_start[r] / TD - m_lost[r];
        if (cnt > 255) cnt = 255;
        if ((m_pos[r] % 2 == 1) && (cnt < 2 || cnt > 3)) hit[3] = 1'b1;
        if (m_pos[r] == 2 && cnt < 10) hit[3] = 1'b1;
`endif
        if (r == 1 && m_pos[r] == 3 && tgt == 0) m_cyc++;
        m_pos[r] = tgt; m_start[r] = n_edges; m_lost[r] = 0;
      end
    end
    m_err = (clr ? 4'b0000 : m_err) | hit;
    m_s[0] = road1;
    m_s[1] = road2;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("err_vec", 32'(err_vec), 32'(m_err));
    check("alarm", 32'(alarm), 32'(|m_err));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
  endtask

  task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
    road1 = a;
    road2 = b;
    repeat (n) cyc();
    $display("step road1=%b road2=%b cycles=%0d err_vec=%b cycle_cnt=%0d",
             a, b, n, err_vec, cycle_cnt);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_err_vec", 32'(err_vec), 32'd0);
    check("reset_alarm", 32'(alarm), 32'd0);
    check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("step reset");
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  function automatic logic [2:0] rand_code();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 2) return 3'($urandom);
    case (k % 3)
      0:       return R;
      1:       return Y;
      default: return G;
    endcase
  endfunction

  initial begin
    model_reset();
    #2;
    apply_reset();

    // Legal cycle on both roads.
    hold(R, R, 3);
    hold(Y, R, 9);
    hold(G, R, 41);
    hold(Y, R, 9);
    hold(R, Y, 9);
    hold(R, G, 41);
    hold(R, Y, 9);
    hold(R, R, 2);
    check("legal_cycle_cnt", 32'(cycle_cnt), 32'd1);
    check("legal_err_vec", 32'(err_vec), 32'd0);

    // Red straight to green, then clear.
    apply_reset();
    hold(R, R, 3);
    hold(G, R, 2);
    check("seq_err_vec", 32'(err_vec), 32'b0100);
    check("seq_alarm", 32'(alarm), 32'd1);
    pulse_clr();
    check("seq_cleared", 32'(err_vec), 32'd0);
    hold(G, R, 2);

    // One invalid sample on road 1; its phase must survive it.
    apply_reset();
    hold(R, R, 3);
    hold(3'b011, R, 1);
    hold(R, R, 1);
    check("onehot_err_vec", 32'(err_vec), 32'b0001);
    hold(Y, R, 9);
    hold(G, R, 2);
    check("onehot_phase_kept", 32'(err_vec), 32'b0001);

    // Conflict with clr in the same cycle.
    apply_reset();
    hold(R, R, 3);
    hold(R, Y, 3);
    road1 = G;
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("conflict_bit", 32'(err_vec[1]), 32'd1);
    hold(R, Y, 2);

    // Short green, then over-long yellow.
    apply_reset();
    hold(R, R, 3);
    hold(Y, R, 9);
    hold(G, R, 21);
    hold(Y, R, 2);
    check("short_green", 32'(err_vec), 32'(TIME_FLAG));
    hold(Y, R, 15);
    hold(R, R, 2);
    check("long_yellow", 32'(err_vec), 32'(TIME_FLAG));

    // Reset mid-green, then resynchronisation.
    hold(Y, R, 9);
    hold(G, R, 10);
    apply_reset();
    hold(Y, R, 9);
    hold(G, R, 9);
    check("post_reset_err", 32'(err_vec), 32'd0);
    check("post_reset_cnt", 32'(cycle_cnt), 32'd0);
    hold(R, R, 3);

    // Randomised near-legal cycles around the duration limits.
    for (int i = 0; i < 8; i++) begin
      pulse_clr();
      hold(Y, R, int'($urandom_range(5, 18)));
      hold(G, R, int'($urandom_range(33, 50)));
      hold(Y, R, int'($urandom_range(5, 18)));
      hold(R, Y, int'($urandom_range(5, 18)));
      hold(R, G, int'($urandom_range(33, 50)));
      hold(R, Y, int'($urandom_range(5, 18)));
      hold(R, R, int'($urandom_range(1, 4)));
    end

    // Randomised arbitrary codes with occasional clears and one reset.
    for (int i = 0; i < 40; i++) begin
      if (i == 20) apply_reset();
      if ($urandom_range(0, 3) == 0) pulse_clr();
      hold(rand_code(), rand_code(), int'($urandom_range(1, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
